// File: rtl/floo_narrow_wide_pkg.sv
// Shared types for the narrow/wide chimney slice: narrow AXI channel structs,
// AXI burst/response encodings and the narrow memory responder FSM states.
// No ports; imported by the responder and its burst address helper.
package floo_narrow_wide_pkg;

  localparam int unsigned AxiNarrowAddrWidth = 48;
  localparam int unsigned AxiNarrowDataWidth = 64;
  localparam int unsigned AxiNarrowIdWidth   = 3;
  localparam int unsigned AxiNarrowUserWidth = 1;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef struct packed {
    logic [AxiNarrowIdWidth-1:0]   id;
    logic [AxiNarrowAddrWidth-1:0] addr;
    logic [7:0]                    len;
    logic [2:0]                    size;
    logic [1:0]                    burst;
    logic [AxiNarrowUserWidth-1:0] user;
  } axi_narrow_ax_chan_t;

  typedef struct packed {
    logic [AxiNarrowDataWidth-1:0]   data;
    logic [AxiNarrowDataWidth/8-1:0] strb;
    logic                            last;
    logic [AxiNarrowUserWidth-1:0]   user;
  } axi_narrow_w_chan_t;

  typedef struct packed {
    logic [AxiNarrowIdWidth-1:0]   id;
    logic [1:0]                    resp;
    logic [AxiNarrowUserWidth-1:0] user;
  } axi_narrow_b_chan_t;

  typedef struct packed {
    logic [AxiNarrowIdWidth-1:0]   id;
    logic [AxiNarrowDataWidth-1:0] data;
    logic [1:0]                    resp;
    logic                          last;
    logic [AxiNarrowUserWidth-1:0] user;
  } axi_narrow_r_chan_t;

  typedef struct packed {
    axi_narrow_ax_chan_t aw;
    logic                aw_valid;
    axi_narrow_w_chan_t  w;
    logic                w_valid;
    logic                b_ready;
    axi_narrow_ax_chan_t ar;
    logic                ar_valid;
    logic                r_ready;
  } axi_narrow_out_req_t;

  typedef struct packed {
    logic               aw_ready;
    logic               ar_ready;
    logic               w_ready;
    logic               b_valid;
    axi_narrow_b_chan_t b;
    logic               r_valid;
    axi_narrow_r_chan_t r;
  } axi_narrow_out_rsp_t;

  // Narrow memory responder FSM.
  typedef enum logic [1:0] {
    Idle   = 2'd0,
    Read   = 2'd1,
    Write  = 2'd2,
    WrResp = 2'd3
  } narrow_rsp_state_e;

endpackage

// File: rtl/floo_axi_burst_addr.sv
// Combinational AXI beat address calculator.
// Ports: addr (burst start address), size (log2 bytes per beat), burst type,
// beat (beat index), beat_addr (address of that beat, modulo 2^AddrWidth).
// No 4 KiB boundary handling.
module floo_axi_burst_addr
  import floo_narrow_wide_pkg::*;
#(
  parameter int unsigned AddrWidth = AxiNarrowAddrWidth
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [2:0]           size,
  input  logic [1:0]           burst,
  input  logic [7:0]           beat,
  output logic [AddrWidth-1:0] beat_addr
);

  // WRAP steps like INCR; callers treat WRAP as an error burst anyway.
  always_comb begin
    beat_addr = addr;
    if (burst != BurstFixed) begin
      beat_addr = addr + (AddrWidth'(beat) << size);
    end
  end

endmodule

// File: rtl/floo_narrow_mem_responder.sv
// Narrow AXI subordinate serving a word-addressed flop scratch memory.
// One transaction at a time; FIXED/INCR bursts, byte strobes, OKAY/SLVERR.
// Ports: clk_i, rst_i (async, active-high), axi_req_i (AW/W/AR channels and
// B/R ready from the NI), axi_rsp_o (AW/W/AR ready, B and R channels).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; R/B valid and payload hold until accepted; only aw_ready and
// ar_ready look at request valids (arbitration), all other readies are pure
// functions of the FSM state.
module floo_narrow_mem_responder
  import floo_narrow_wide_pkg::*;
#(
  parameter int unsigned                   NumWords  = 256,
  parameter logic [AxiNarrowAddrWidth-1:0] BaseAddr  = '0,
  parameter type                           axi_req_t = axi_narrow_out_req_t,
  parameter type                           axi_rsp_t = axi_narrow_out_rsp_t,
  parameter int unsigned                   DataWidth = AxiNarrowDataWidth
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o
);

  localparam int unsigned AW        = AxiNarrowAddrWidth;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned ByteBits  = $clog2(StrbWidth);
  localparam int unsigned IdxBits   = $clog2(NumWords);
  localparam logic [AW-1:0] MemBytes = AW'(NumWords * StrbWidth);

  narrow_rsp_state_e state_q, state_d;

  logic                          rr_write_q;  // 1: write wins a tie
  logic [AxiNarrowIdWidth-1:0]   id_q;
  logic [AxiNarrowUserWidth-1:0] user_q;
  logic [AW-1:0]                 addr_q;
  logic [7:0]                    len_q, beat_q;
  logic [2:0]                    size_q;
  logic [1:0]                    burst_q;
  logic                          err_q;

  logic [DataWidth-1:0] mem_q [NumWords];

  logic aw_ready, ar_ready, w_ready, r_valid, b_valid;
  logic aw_hs, ar_hs, w_hs, r_hs, b_hs;
  logic sel_write, last_beat, in_range, rd_ok;
  logic [AW-1:0]      beat_addr, offset;
  logic [IdxBits-1:0] word_idx;

  logic unused_w_user;
  assign unused_w_user = ^axi_req_i.w.user;

  floo_axi_burst_addr #(
    .AddrWidth (AW)
  ) i_burst_addr (
    .addr      (addr_q),
    .size      (size_q),
    .burst     (burst_q),
    .beat      (beat_q),
    .beat_addr (beat_addr)
  );

  // Offset wraps when beat_addr < BaseAddr, so the lower-bound test is explicit.
  assign offset    = beat_addr - BaseAddr;
  assign in_range  = (beat_addr >= BaseAddr) && (offset < MemBytes);
  assign word_idx  = offset[ByteBits +: IdxBits];
  assign last_beat = (beat_q == len_q);
  assign rd_ok     = in_range && !err_q;

  // A lone valid request always wins; on a tie the flag decides.
  assign sel_write = axi_req_i.aw_valid && (rr_write_q || !axi_req_i.ar_valid);

  assign aw_hs = aw_ready && axi_req_i.aw_valid;
  assign ar_hs = ar_ready && axi_req_i.ar_valid;
  assign w_hs  = w_ready  && axi_req_i.w_valid;
  assign r_hs  = r_valid  && axi_req_i.r_ready;
  assign b_hs  = b_valid  && axi_req_i.b_ready;

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= Idle;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle: begin
        if (aw_hs)      state_d = Write;
        else if (ar_hs) state_d = Read;
      end
      Read:    if (r_hs && last_beat) state_d = Idle;
      Write:   if (w_hs && last_beat) state_d = WrResp;
      WrResp:  if (b_hs)              state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  // FSM: outputs. Gating with rst_i drops every valid/ready as soon as reset
  // asserts, without waiting for the state register to settle.
  always_comb begin
    aw_ready = (state_q == Idle)   && !rst_i && sel_write;
    ar_ready = (state_q == Idle)   && !rst_i && axi_req_i.ar_valid && !sel_write;
    w_ready  = (state_q == Write)  && !rst_i;
    r_valid  = (state_q == Read)   && !rst_i;
    b_valid  = (state_q == WrResp) && !rst_i;

    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_ready;
    axi_rsp_o.ar_ready = ar_ready;
    axi_rsp_o.w_ready  = w_ready;
    axi_rsp_o.b_valid  = b_valid;
    axi_rsp_o.b.id     = id_q;
    axi_rsp_o.b.user   = user_q;
    axi_rsp_o.b.resp   = err_q ? RespSlvErr : RespOkay;
    axi_rsp_o.r_valid  = r_valid;
    axi_rsp_o.r.id     = id_q;
    axi_rsp_o.r.user   = user_q;
    axi_rsp_o.r.data   = rd_ok ? mem_q[word_idx] : '0;
    axi_rsp_o.r.resp   = rd_ok ? RespOkay : RespSlvErr;
    axi_rsp_o.r.last   = last_beat;
  end

  // Transaction context and beat counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_write_q <= 1'b1;
      id_q       <= '0;
      user_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (aw_hs || ar_hs) begin
        rr_write_q <= ~rr_write_q;
        beat_q     <= '0;
      end
      if (aw_hs) begin
        id_q    <= axi_req_i.aw.id;
        user_q  <= axi_req_i.aw.user;
        addr_q  <= axi_req_i.aw.addr;
        len_q   <= axi_req_i.aw.len;
        size_q  <= axi_req_i.aw.size;
        burst_q <= axi_req_i.aw.burst;
        err_q   <= (axi_req_i.aw.burst == BurstWrap);
      end else if (ar_hs) begin
        id_q    <= axi_req_i.ar.id;
        user_q  <= axi_req_i.ar.user;
        addr_q  <= axi_req_i.ar.addr;
        len_q   <= axi_req_i.ar.len;
        size_q  <= axi_req_i.ar.size;
        burst_q <= axi_req_i.ar.burst;
        err_q   <= (axi_req_i.ar.burst == BurstWrap);
      end
      if (r_hs && !last_beat) beat_q <= beat_q + 8'd1;
      if (w_hs) begin
        // The beat count, not w_last, ends the burst; a mismatch only flags.
        err_q <= err_q || !in_range || (axi_req_i.w.last != last_beat);
        if (!last_beat) beat_q <= beat_q + 8'd1;
      end
    end
  end

  // Scratch memory: byte-strobed writes on the W handshake edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else if (w_hs && in_range) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (axi_req_i.w.strb[b]) mem_q[word_idx][b*8 +: 8] <= axi_req_i.w.data[b*8 +: 8];
      end
    end
  end

endmodule
